// File: rtl/spi_gpg_cmd_decoder.sv
// SPI command decoder for the GoPiGo3 PWM/LED protocol: validates each slave-select
// framed byte stream and commits motor PWM or RGB LED registers when the frame ends.
module spi_gpg_cmd_decoder #(
    parameter logic [7:0] C_SPI_ADDR    = 8'h08,
    parameter logic [7:0] C_MSG_SET_PWM = 8'h0A,
    parameter logic [7:0] C_MSG_SET_LED = 8'h06,
    parameter int         C_ERR_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_ss_n,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic [7:0]         motor_pwm_left_o,
    output logic [7:0]         motor_pwm_rght_o,
    output logic [23:0]        led_eye_left_rgb_o,
    output logic [23:0]        led_eye_rght_rgb_o,
    output logic [23:0]        led_blink_left_rgb_o,
    output logic [23:0]        led_blink_rght_rgb_o,
    output logic               upd_o,
    output logic [2:0]         upd_id_o,
    output logic               err_o,
    output logic [C_ERR_W-1:0] err_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TYPE,
        S_TARGET,
        S_PAYLOAD,
        S_WAIT_END,
        S_DISCARD
    } state_t;

    state_t      state;
    state_t      st_b;
    logic        ss_n_d;
    logic        frame_start;
    logic        frame_end;
    logic        byte_ok;
    logic        is_led;
    logic        is_led_b;
    logic [2:0]  len;
    logic [2:0]  len_b;
    logic [2:0]  cnt;
    logic [2:0]  cnt_b;
    logic [2:0]  tgt_id;
    logic [2:0]  id_b;
    logic [23:0] shadow;
    logic [23:0] shadow_b;

    assign frame_start = ss_n_d & ~spi_ss_n;
    assign frame_end   = ~ss_n_d & spi_ss_n;
    // A byte landing in the frame-end cycle still belongs to the frame.
    assign byte_ok     = rx_valid & ~(spi_ss_n & ss_n_d);

    always_comb begin
        st_b     = state;
        len_b    = len;
        cnt_b    = cnt;
        id_b     = tgt_id;
        is_led_b = is_led;
        shadow_b = shadow;
        if (byte_ok) begin
            case (state)
                S_ADDR: begin
                    st_b = (rx_data == C_SPI_ADDR) ? S_TYPE : S_DISCARD;
                end
                S_TYPE: begin
                    if (rx_data == C_MSG_SET_PWM) begin
                        len_b    = 3'd3;
                        cnt_b    = 3'd1;
                        is_led_b = 1'b0;
                        st_b     = S_TARGET;
                    end else if (rx_data == C_MSG_SET_LED) begin
                        len_b    = 3'd5;
                        cnt_b    = 3'd1;
                        is_led_b = 1'b1;
                        st_b     = S_TARGET;
                    end else begin
                        st_b = S_DISCARD;
                    end
                end
                S_TARGET: begin
                    cnt_b = cnt + 3'd1;
                    st_b  = S_PAYLOAD;
                    if (!is_led) begin
                        case (rx_data)
                            8'h01:   id_b = 3'd0;
                            8'h02:   id_b = 3'd1;
                            default: st_b = S_DISCARD;
                        endcase
                    end else begin
                        case (rx_data)
                            8'h02:   id_b = 3'd2;
                            8'h01:   id_b = 3'd3;
                            8'h04:   id_b = 3'd4;
                            8'h08:   id_b = 3'd5;
                            default: st_b = S_DISCARD;
                        endcase
                    end
                end
                S_PAYLOAD: begin
                    // Shifting in R, G, B leaves them at [23:16], [15:8], [7:0]; PWM lands in [7:0].
                    shadow_b = {shadow[15:0], rx_data};
                    cnt_b    = cnt + 3'd1;
                    if (cnt_b == len) begin
                        st_b = S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    st_b = S_DISCARD;
                end
                default: begin
                    st_b = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            ss_n_d               <= 1'b1;
            is_led               <= 1'b0;
            len                  <= 3'd0;
            cnt                  <= 3'd0;
            tgt_id               <= 3'd0;
            shadow               <= 24'h0;
            motor_pwm_left_o     <= 8'h0;
            motor_pwm_rght_o     <= 8'h0;
            led_eye_left_rgb_o   <= 24'h0;
            led_eye_rght_rgb_o   <= 24'h0;
            led_blink_left_rgb_o <= 24'h0;
            led_blink_rght_rgb_o <= 24'h0;
            upd_o                <= 1'b0;
            upd_id_o             <= 3'd0;
            err_o                <= 1'b0;
            err_cnt_o            <= '0;
        end else begin
            ss_n_d <= spi_ss_n;
            upd_o  <= 1'b0;
            err_o  <= 1'b0;
            is_led <= is_led_b;
            len    <= len_b;
            cnt    <= cnt_b;
            tgt_id <= id_b;
            shadow <= shadow_b;
            if (frame_end) begin
                state <= S_IDLE;
                if (st_b == S_WAIT_END) begin
                    upd_o    <= 1'b1;
                    upd_id_o <= id_b;
                    case (id_b)
                        3'd0:    motor_pwm_left_o     <= shadow_b[7:0];
                        3'd1:    motor_pwm_rght_o     <= shadow_b[7:0];
                        3'd2:    led_eye_left_rgb_o   <= shadow_b;
                        3'd3:    led_eye_rght_rgb_o   <= shadow_b;
                        3'd4:    led_blink_left_rgb_o <= shadow_b;
                        3'd5:    led_blink_rght_rgb_o <= shadow_b;
                        default: ;
                    endcase
                end else if (st_b != S_IDLE) begin
                    err_o <= 1'b1;
                    if (err_cnt_o != {C_ERR_W{1'b1}}) begin
                        err_cnt_o <= err_cnt_o + {{(C_ERR_W-1){1'b0}}, 1'b1};
                    end
                end
            end else if (frame_start && state == S_IDLE) begin
                state <= S_ADDR;
            end else begin
                state <= st_b;
            end
        end
    end

endmodule

// File: tb/tb_spi_gpg_cmd_decoder.sv
// Bench for spi_gpg_cmd_decoder: directed frame table, randomized frames against a
// frame-level decode model, error counter saturation and mid-frame reset.
module tb_spi_gpg_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_ss_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  motor_pwm_left_o;
    logic [7:0]  motor_pwm_rght_o;
    logic [23:0] led_eye_left_rgb_o;
    logic [23:0] led_eye_rght_rgb_o;
    logic [23:0] led_blink_left_rgb_o;
    logic [23:0] led_blink_rght_rgb_o;
    logic        upd_o;
    logic [2:0]  upd_id_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    spi_gpg_cmd_decoder dut (
        .clk                  (clk),
        .rst                  (rst),
        .spi_ss_n             (spi_ss_n),
        .rx_valid             (rx_valid),
        .rx_data              (rx_data),
        .motor_pwm_left_o     (motor_pwm_left_o),
        .motor_pwm_rght_o     (motor_pwm_rght_o),
        .led_eye_left_rgb_o   (led_eye_left_rgb_o),
        .led_eye_rght_rgb_o   (led_eye_rght_rgb_o),
        .led_blink_left_rgb_o (led_blink_left_rgb_o),
        .led_blink_rght_rgb_o (led_blink_rght_rgb_o),
        .upd_o                (upd_o),
        .upd_id_o             (upd_id_o),
        .err_o                (err_o),
        .err_cnt_o            (err_cnt_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;
    int err_seen = 0;

    // scoreboard state: one expected value per output register
    logic [23:0] exp_out[6];
    logic [7:0]  exp_cnt;

    typedef struct {
        logic [7:0]  b[8];
        int          n;
        bit          rise_last;
        bit          exp_ok;
        logic [2:0]  exp_id;
        logic [23:0] exp_val;
    } vec_t;

    vec_t vecs[13];

    always @(posedge clk) begin
        if (upd_o) upd_seen++;
        if (err_o) err_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        chk({name, "/pwm_l"},   {24'h0, motor_pwm_left_o}, {8'h0, exp_out[0]});
        chk({name, "/pwm_r"},   {24'h0, motor_pwm_rght_o}, {8'h0, exp_out[1]});
        chk({name, "/eye_l"},   {8'h0, led_eye_left_rgb_o},   {8'h0, exp_out[2]});
        chk({name, "/eye_r"},   {8'h0, led_eye_rght_rgb_o},   {8'h0, exp_out[3]});
        chk({name, "/blink_l"}, {8'h0, led_blink_left_rgb_o}, {8'h0, exp_out[4]});
        chk({name, "/blink_r"}, {8'h0, led_blink_rght_rgb_o}, {8'h0, exp_out[5]});
        chk({name, "/err_cnt"}, {24'h0, err_cnt_o}, {24'h0, exp_cnt});
    endtask

    function automatic vec_t mk(input logic [63:0] bytes, input int n, input bit rise,
                                input bit ok, input logic [2:0] id, input logic [23:0] val);
        vec_t v;
        for (int i = 0; i < 8; i++) v.b[i] = bytes[63-8*i -: 8];
        v.n = n;
        v.rise_last = rise;
        v.exp_ok = ok;
        v.exp_id = id;
        v.exp_val = val;
        return v;
    endfunction

    // Whole-frame reference: a frame is accepted only if every field is legal and its
    // length is exactly 4 (PWM) or 6 (LED) bytes including the address.
    function automatic void model(input logic [7:0] b[8], input int n, output bit ok,
                                  output logic [2:0] id, output logic [23:0] val);
        bit pwm;
        bit tgt_ok;
        ok = 1'b0;
        id = 3'd0;
        val = 24'h0;
        tgt_ok = 1'b0;
        if (n < 3 || b[0] != 8'h08) return;
        if (b[1] != 8'h0A && b[1] != 8'h06) return;
        pwm = (b[1] == 8'h0A);
        if (pwm) begin
            if (b[2] == 8'h01) begin id = 3'd0; tgt_ok = 1'b1; end
            if (b[2] == 8'h02) begin id = 3'd1; tgt_ok = 1'b1; end
        end else begin
            if (b[2] == 8'h02) begin id = 3'd2; tgt_ok = 1'b1; end
            if (b[2] == 8'h01) begin id = 3'd3; tgt_ok = 1'b1; end
            if (b[2] == 8'h04) begin id = 3'd4; tgt_ok = 1'b1; end
            if (b[2] == 8'h08) begin id = 3'd5; tgt_ok = 1'b1; end
        end
        if (!tgt_ok || n != (pwm ? 4 : 6)) return;
        ok = 1'b1;
        val = pwm ? {16'h0, b[3]} : {b[3], b[4], b[5]};
    endfunction

    // driver tasks
    task automatic send_byte(input logic [7:0] d, input bit with_rise);
        rx_data = d;
        rx_valid = 1'b1;
        if (with_rise) spi_ss_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] b[8], input int n, input bit rise, input bit ok,
                             input logic [2:0] id, input logic [23:0] val, input string name);
        int u0;
        int e0;
        u0 = upd_seen;
        e0 = err_seen;
        spi_ss_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], rise && (i == n - 1));
            if (i < n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if (!(rise && n > 0)) begin
            spi_ss_n = 1'b1;
            @(negedge clk);
        end
        if (ok) exp_out[id] = (id < 3'd2) ? {16'h0, val[7:0]} : val;
        else if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        chk({name, "/upd"}, {31'h0, upd_o}, {31'h0, ok});
        chk({name, "/err"}, {31'h0, err_o}, {31'h0, !ok});
        if (ok) chk({name, "/upd_id"}, {29'h0, upd_id_o}, {29'h0, id});
        check_all(name);
        @(negedge clk);
        chk({name, "/upd_width"}, {31'h0, upd_o}, 32'h0);
        chk({name, "/err_width"}, {31'h0, err_o}, 32'h0);
        chk({name, "/upd_pulses"}, upd_seen - u0, {31'h0, ok});
        chk({name, "/err_pulses"}, err_seen - e0, {31'h0, !ok});
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_ss_n = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) exp_out[i] = 24'h0;
        exp_cnt = 8'h0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  rb[8];
        int          rn;
        bit          rrise;
        bit          rok;
        logic [2:0]  rid;
        logic [23:0] rval;
        int          u0;
        int          e0;

        vecs[0]  = mk(64'h08_0A_01_9C_00_00_00_00, 4, 0, 1, 3'd0, 24'h00009C);
        vecs[1]  = mk(64'h08_06_08_FF_80_01_00_00, 6, 0, 1, 3'd5, 24'hFF8001);
        vecs[2]  = mk(64'h08_06_01_10_20_30_00_00, 6, 0, 1, 3'd3, 24'h102030);
        vecs[3]  = mk(64'h07_0A_01_10_00_00_00_00, 4, 0, 0, 3'd0, 24'h0);
        vecs[4]  = mk(64'h08_0B_01_10_00_00_00_00, 4, 0, 0, 3'd0, 24'h0);
        vecs[5]  = mk(64'h08_0A_03_10_00_00_00_00, 4, 0, 0, 3'd0, 24'h0);
        vecs[6]  = mk(64'h08_06_02_11_22_00_00_00, 5, 0, 0, 3'd0, 24'h0);
        vecs[7]  = mk(64'h08_0A_02_10_55_00_00_00, 5, 0, 0, 3'd0, 24'h0);
        vecs[8]  = mk(64'h08_0A_02_64_00_00_00_00, 4, 1, 1, 3'd1, 24'h000064);
        vecs[9]  = mk(64'h08_06_04_AA_BB_CC_00_00, 6, 1, 1, 3'd4, 24'hAABBCC);
        vecs[10] = mk(64'h08_06_02_12_34_56_00_00, 6, 0, 1, 3'd2, 24'h123456);
        vecs[11] = mk(64'h08_0A_01_00_00_00_00_00, 3, 0, 0, 3'd0, 24'h0);
        vecs[12] = mk(64'h00_00_00_00_00_00_00_00, 0, 0, 0, 3'd0, 24'h0);

        do_reset();
        chk("reset/upd", {31'h0, upd_o}, 32'h0);
        chk("reset/err", {31'h0, err_o}, 32'h0);
        chk("reset/upd_id", {29'h0, upd_id_o}, 32'h0);
        check_all("reset");

        for (int i = 0; i < 13; i++) begin
            run_frame(vecs[i].b, vecs[i].n, vecs[i].rise_last, vecs[i].exp_ok,
                      vecs[i].exp_id, vecs[i].exp_val, $sformatf("vec%0d", i));
            if (i == 7) chk("t3_err_cnt", {24'h0, err_cnt_o}, 32'h5);
        end

        // rx_valid with slave select high must be ignored
        u0 = upd_seen;
        e0 = err_seen;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'h08, 1'b0);
        repeat (2) @(negedge clk);
        chk("idle_rx/upd_pulses", upd_seen - u0, 32'h0);
        chk("idle_rx/err_pulses", err_seen - e0, 32'h0);
        check_all("idle_rx");
        run_frame(vecs[0].b, vecs[0].n, 1'b0, 1'b1, 3'd0, 24'h00009C, "after_idle_rx");

        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
            if ($urandom_range(0, 7) != 0) rb[0] = 8'h08;
            case ($urandom_range(0, 4))
                0, 1:    rb[1] = 8'h0A;
                2, 3:    rb[1] = 8'h06;
                default: ;
            endcase
            case ($urandom_range(0, 5))
                0:       rb[2] = 8'h01;
                1:       rb[2] = 8'h02;
                2:       rb[2] = 8'h04;
                3:       rb[2] = 8'h08;
                4:       rb[2] = 8'h01;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) rn = (rb[1] == 8'h0A) ? 4 : 6;
            else rn = $urandom_range(0, 7);
            rrise = (rn > 0) && ($urandom_range(0, 2) == 0);
            model(rb, rn, rok, rid, rval);
            run_frame(rb, rn, rrise, rok, rid, rval, $sformatf("rnd%0d", k));
        end

        rb[0] = 8'h07;
        for (int k = 0; k < 300; k++) begin
            run_frame(rb, 1, 1'b0, 1'b0, 3'd0, 24'h0, $sformatf("sat%0d", k));
        end
        chk("sat/err_cnt", {24'h0, err_cnt_o}, 32'hFF);

        // reset in the middle of an LED payload
        u0 = upd_seen;
        e0 = err_seen;
        spi_ss_n = 1'b0;
        @(negedge clk);
        send_byte(8'h08, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        do_reset();
        chk("midrst/upd_pulses", upd_seen - u0, 32'h0);
        chk("midrst/err_pulses", err_seen - e0, 32'h0);
        check_all("midrst");
        rb[0] = 8'h08; rb[1] = 8'h06; rb[2] = 8'h02;
        rb[3] = 8'hA1; rb[4] = 8'hB2; rb[5] = 8'hC3;
        run_frame(rb, 6, 1'b0, 1'b1, 3'd2, 24'hA1B2C3, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
